pixel_stream_tx: RTL and testbench

Frame transmitter that is the write-side counterpart of the raw-data reader. It holds one WIDTH×HEIGHT RGB frame in fixed-point form (`size_int` words, `ScaleBit` fractional bits), loaded through a random-access write port. On `Start` it streams the frame out in raster order as 8-bit R/G/B, one pixel per accepted handshake, with start-of-frame and end-of-line flags. It sits after the colour-correction stage and feeds file-dump benches or downstream pixel sinks.

---
 rtl/pixel_stream_tx_pkg.sv | 19 +
 rtl/pixel_round_sat.sv | 39 +++
 rtl/pixel_stream_tx.sv | 174 +++++++++++++++++
 tb/tb_pixel_stream_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_tx_pkg.sv
// Shared types and constants for the pixel frame transmitter.
// Fixed-point format: size_int-bit signed words with ScaleBit fractional bits.
// Output pixels are size_char bits wide.
package pixel_stream_tx_pkg;

  localparam int size_char = 8;
  localparam int size_int  = 16;
  localparam int ScaleBit  = 6;

  // One extra bit so that adding the rounding constant can never overflow.
  localparam int CONV_W = size_int + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } tx_state_e;

endpackage

// File: rtl/pixel_round_sat.sv
// Converts one fixed-point component to an 8-bit pixel (round half up, then clamp or wrap).
// Latency: combinational.
// Backpressure: none (pure function). Clamping is enabled by PIXEL_TX_SATURATE_EN.
module pixel_round_sat
  import pixel_stream_tx_pkg::*;
(
  input  logic [size_int-1:0]  i_v,
  output logic [size_char-1:0] o_pix
);

  localparam logic signed [CONV_W-1:0] HALF = CONV_W'(2 ** (ScaleBit - 1));

  logic signed [CONV_W-1:0] w_sum;

  assign w_sum = $signed({i_v[size_int-1], i_v}) + HALF;

`ifdef PIXEL_TX_SATURATE_EN
  logic signed [CONV_W-1:0] w_q;

  assign w_q = w_sum >>> ScaleBit;

  // Negative results clamp to black, anything above 255 clamps to white.
  always_comb begin
    o_pix = w_q[size_char-1:0];
    if (w_sum[CONV_W-1]) begin
      o_pix = '0;
    end else if (w_q > CONV_W'(255)) begin
      o_pix = '1;
    end
  end
`else
  // Without clamping the pixel is simply the integer byte of the rounded sum.
  assign o_pix = w_sum[ScaleBit+size_char-1:ScaleBit];

  logic w_unused_bits;
  assign w_unused_bits = ^{w_sum[CONV_W-1:ScaleBit+size_char], w_sum[ScaleBit-1:0]};
`endif

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame buffer + raster streamer: holds one RGB frame, sends it as 8-bit pixels with Sof/Eol.
// Latency: first pixel valid two cycles after Start is sampled; then one pixel per clock.
// Backpressure: Valid/Ready; outputs hold while Ready is low and no read is issued. Macro: PIXEL_TX_SATURATE_EN.
module pixel_stream_tx
  import pixel_stream_tx_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int HEIGHT = 15,
  parameter int ADDR_W = 9
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 WrEn,
  input  logic [ADDR_W-1:0]    WrAddr,
  input  logic [size_int-1:0]  WrR,
  input  logic [size_int-1:0]  WrG,
  input  logic [size_int-1:0]  WrB,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Valid,
  input  logic                 Ready,
  output logic [size_char-1:0] R_out,
  output logic [size_char-1:0] G_out,
  output logic [size_char-1:0] B_out,
  output logic                 Sof,
  output logic                 Eol,
  output logic                 Done
);

  localparam int SUM   = WIDTH * HEIGHT;
  localparam int IDX_W = ADDR_W + 1;  // read index must be able to hold SUM itself
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  tx_state_e r_state;
  tx_state_e w_state_nxt;

  logic [size_int-1:0] r_mem_r [SUM];
  logic [size_int-1:0] r_mem_g [SUM];
  logic [size_int-1:0] r_mem_b [SUM];

  // Read stage: one word fetched from the buffer, waiting to enter the output register.
  logic                r_s1_vld;
  logic [size_int-1:0] r_s1_r;
  logic [size_int-1:0] r_s1_g;
  logic [size_int-1:0] r_s1_b;
  logic [IDX_W-1:0]    r_rd_idx;

  // Output register and raster position of the pixel it holds.
  logic                 r_out_vld;
  logic [size_char-1:0] r_r_out;
  logic [size_char-1:0] r_g_out;
  logic [size_char-1:0] r_b_out;
  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;

  logic                 w_wr;
  logic                 w_xfer;
  logic                 w_last_xfer;
  logic                 w_out_ld;
  logic                 w_s1_mv;
  logic                 w_issue;
  logic                 w_col_end;
  logic                 w_row_end;
  logic [size_char-1:0] w_r8;
  logic [size_char-1:0] w_g8;
  logic [size_char-1:0] w_b8;

  // Frame is frozen while streaming so a transmitted frame is always coherent.
  assign w_wr = WrEn && (r_state != ST_STREAM) && ({1'b0, WrAddr} < IDX_W'(SUM));

  assign w_col_end   = (r_col == COL_W'(WIDTH - 1));
  assign w_row_end   = (r_row == ROW_W'(HEIGHT - 1));
  assign w_xfer      = r_out_vld && Ready;
  assign w_last_xfer = w_xfer && w_col_end && w_row_end;

  // Output register can take a new word when empty or when its current word leaves.
  assign w_out_ld = !r_out_vld || Ready;
  assign w_s1_mv  = r_s1_vld && w_out_ld;
  assign w_issue  = (r_state == ST_STREAM) && (r_rd_idx < IDX_W'(SUM)) && (!r_s1_vld || w_s1_mv);

  pixel_round_sat u_conv_r (.i_v(r_s1_r), .o_pix(w_r8));
  pixel_round_sat u_conv_g (.i_v(r_s1_g), .o_pix(w_g8));
  pixel_round_sat u_conv_b (.i_v(r_s1_b), .o_pix(w_b8));

  // Buffer write port and synchronous read into the read stage; deliberately not reset.
  always_ff @(posedge Clock) begin
    if (w_wr) begin
      r_mem_r[WrAddr] <= WrR;
      r_mem_g[WrAddr] <= WrG;
      r_mem_b[WrAddr] <= WrB;
    end
    if (w_issue) begin
      r_s1_r <= r_mem_r[r_rd_idx[ADDR_W-1:0]];
      r_s1_g <= r_mem_g[r_rd_idx[ADDR_W-1:0]];
      r_s1_b <= r_mem_b[r_rd_idx[ADDR_W-1:0]];
    end
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: Start only counts in IDLE; DONE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (Start) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_last_xfer) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Read pipeline, output register and raster counters; everything is cleared outside STREAM.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rd_idx  <= '0;
      r_s1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_r_out   <= '0;
      r_g_out   <= '0;
      r_b_out   <= '0;
      r_col     <= '0;
      r_row     <= '0;
    end else if (r_state != ST_STREAM) begin
      r_rd_idx  <= '0;
      r_s1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
    end else begin
      if (w_issue) begin
        r_s1_vld <= 1'b1;
        r_rd_idx <= r_rd_idx + IDX_W'(1);
      end else if (w_s1_mv) begin
        r_s1_vld <= 1'b0;
      end

      if (w_out_ld) begin
        r_out_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_r_out <= w_r8;
          r_g_out <= w_g8;
          r_b_out <= w_b8;
        end
      end

      if (w_xfer) begin
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign Busy  = (r_state != ST_IDLE);
  assign Done  = (r_state == ST_DONE);
  assign Valid = r_out_vld;
  assign R_out = r_r_out;
  assign G_out = r_g_out;
  assign B_out = r_b_out;
  assign Sof   = r_out_vld && (r_row == '0) && (r_col == '0);
  assign Eol   = r_out_vld && w_col_end;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Randomised bench for pixel_stream_tx against a behavioural frame model.
// Checks reset, start latency, raster order, flags, rounding/saturation, backpressure, Done and reset abort.
// Honours PIXEL_TX_SATURATE_EN to pick the expected conversion.
module tb_pixel_stream_tx;
  import pixel_stream_tx_pkg::*;

  localparam int W   = 20;
  localparam int H   = 15;
  localparam int SUM = W * H;
  localparam int AW  = 9;
  localparam int ONE = 1 << ScaleBit;

  logic                 Clock = 1'b0;
  logic                 Reset, WrEn, Start, Ready;
  logic [AW-1:0]        WrAddr;
  logic [size_int-1:0]  WrR, WrG, WrB;
  logic                 Busy, Valid, Sof, Eol, Done;
  logic [size_char-1:0] R_out, G_out, B_out;

  always #5 Clock = ~Clock;

  pixel_stream_tx #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrR(WrR), .WrG(WrG), .WrB(WrB), .Start(Start), .Busy(Busy),
    .Valid(Valid), .Ready(Ready), .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .Sof(Sof), .Eol(Eol), .Done(Done)
  );

  int n_cmp = 0;
  int n_err = 0;

  int m_r [SUM];
  int m_g [SUM];
  int m_b [SUM];
  int rx_r [SUM];
  int rx_g [SUM];
  int first_vld_cyc, done_cyc, last_xfer_cyc, n_xfer;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Round half up: floor((v + half) / 2^ScaleBit), then clamp or wrap to a byte.
  function automatic int conv(input int v);
    int n, q;
    n = v + ONE / 2;
    q = n / ONE;
    if (n < 0 && (n % ONE) != 0) q = q - 1;
`ifdef PIXEL_TX_SATURATE_EN
    if (q < 0) return 0;
    if (q > 255) return 255;
    return q;
`else
    return ((q % 256) + 256) % 256;
`endif
  endfunction

  function automatic int exp_word(input int k);
    if (k >= SUM) return -1;
    return (conv(m_r[k]) << 18) | (conv(m_g[k]) << 10) | (conv(m_b[k]) << 2)
         | (int'(k == 0) << 1) | int'((k % W) == W - 1);
  endfunction

  function automatic int rand_val();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // Write one pixel while the block is idle; the model ignores out-of-range addresses.
  task automatic wr_pix(input int addr, input int r, input int g, input int b);
    @(negedge Clock);
    WrEn = 1'b1; WrAddr = AW'(addr);
    WrR = size_int'(r); WrG = size_int'(g); WrB = size_int'(b);
    @(posedge Clock);
    #1 WrEn = 1'b0;
    if (addr < SUM) begin
      m_r[addr] = r; m_g[addr] = g; m_b[addr] = b;
    end
  endtask

  // mode: 0 Ready high, 1 Ready toggling, 2 Ready random.
  task automatic run_frame(input int mode, input int rst_at, input bit mid_wr,
                           input bit done_wr, input bit start_wr, input bit mid_start);
    int  dword, prev_word, n_done;
    bit  prev_hold;
    int  v0r, v0g, v0b;
    n_xfer = 0; first_vld_cyc = -1; done_cyc = -1; last_xfer_cyc = -100;
    prev_hold = 1'b0; prev_word = 0;
    @(negedge Clock);
    chk_eq("idle_before_start", int'(Busy), 0);
    Start = 1'b1;
    Ready = 1'b1;
    if (start_wr) begin
      v0r = rand_val(); v0g = rand_val(); v0b = rand_val();
      WrEn = 1'b1; WrAddr = '0;
      WrR = size_int'(v0r); WrG = size_int'(v0g); WrB = size_int'(v0b);
      m_r[0] = v0r; m_g[0] = v0g; m_b[0] = v0b;
    end
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge Clock);
      Start = 1'b0; WrEn = 1'b0;
      dword = int'({R_out, G_out, B_out, Sof, Eol});
      if (cyc == 1) begin
        chk_eq("busy_after_start", int'(Busy), 1);
        chk_eq("vld_lat1", int'(Valid), 0);
      end
      if (cyc == 2) chk_eq("vld_lat2", int'(Valid), 0);
      if (cyc == 3) begin
        chk_eq("vld_lat3", int'(Valid), 1);
        chk_eq("sof_first", int'(Sof), 1);
      end
      if (prev_hold) begin
        chk_eq("hold_vld", int'(Valid), 1);
        chk_eq($sformatf("hold_pix%0d", n_xfer), dword, prev_word);
      end
      if (Valid && first_vld_cyc < 0) first_vld_cyc = cyc;

      if (Done) begin
        done_cyc = cyc;
        chk_eq("done_gap", cyc - last_xfer_cyc, 1);
        chk_eq("done_vld_low", int'(Valid), 0);
        chk_eq("busy_in_done", int'(Busy), 1);
        chk_eq("pix_count", n_xfer, SUM);
        Start = 1'b1;
        if (done_wr) begin
          WrEn = 1'b1; WrAddr = AW'(SUM - 1);
          WrR = size_int'(8'hAA * ONE); WrG = WrR; WrB = WrR;
          m_r[SUM-1] = 8'hAA * ONE; m_g[SUM-1] = 8'hAA * ONE; m_b[SUM-1] = 8'hAA * ONE;
        end
        @(negedge Clock);
        Start = 1'b0; WrEn = 1'b0;
        chk_eq("done_one_cycle", int'(Done), 0);
        chk_eq("busy_fall", int'(Busy), 0);
        @(negedge Clock);
        chk_eq("start_in_done_ignored", int'(Busy), 0);
        return;
      end

      if (rst_at >= 0 && n_xfer == rst_at) begin
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk_eq("rst_vld", int'(Valid), 0);
        chk_eq("rst_busy", int'(Busy), 0);
        n_done = 0;
        repeat (20) begin
          @(negedge Clock);
          if (Done) n_done++;
        end
        chk_eq("rst_no_done", n_done, 0);
        return;
      end

      case (mode)
        0:       Ready = 1'b1;
        1:       Ready = ~Ready;
        default: Ready = 1'($urandom_range(1));
      endcase
      if (mid_wr && cyc == 50) begin
        WrEn = 1'b1; WrAddr = AW'(SUM - 1);
        WrR = size_int'(8'hAA * ONE); WrG = WrR; WrB = WrR;
      end
      if (mid_start && cyc == 30) Start = 1'b1;

      if (Valid && Ready) begin
        chk_eq($sformatf("pix%0d", n_xfer), dword, exp_word(n_xfer));
        if (n_xfer < SUM) begin
          rx_r[n_xfer] = int'(R_out);
          rx_g[n_xfer] = int'(G_out);
        end
        last_xfer_cyc = cyc;
        n_xfer++;
      end
      prev_hold = Valid && !Ready;
      prev_word = dword;
    end
    chk_eq("frame_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    Reset = 1'b1; WrEn = 1'b0; Start = 1'b0; Ready = 1'b1;
    WrAddr = '0; WrR = '0; WrG = '0; WrB = '0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk_eq("rst_valid", int'(Valid), 0);
    chk_eq("rst_busy0", int'(Busy), 0);
    chk_eq("rst_done", int'(Done), 0);
    chk_eq("rst_sof", int'(Sof), 0);
    chk_eq("rst_eol", int'(Eol), 0);
    chk_eq("rst_rgb", int'({R_out, G_out, B_out}), 0);

    // Frame 1: ramp on red, conversion corner cases on green, random blue.
    for (int i = 0; i < SUM; i++) begin
      int g;
      case (i)
        0:       g = 8'h12 * ONE + ONE / 2;
        1:       g = 8'h12 * ONE + ONE / 2 - 1;
        2:       g = 300 * ONE;
        3:       g = -(5 * ONE);
        default: g = rand_val();
      endcase
      wr_pix(i, (i % 256) * ONE, g, rand_val());
    end
    wr_pix(SUM, 8'h55 * ONE, 8'h55 * ONE, 8'h55 * ONE);
    wr_pix(511, 8'h66 * ONE, 8'h66 * ONE, 8'h66 * ONE);
    run_frame(0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_eq("ramp_255", rx_r[255], 8'hFF);
    chk_eq("ramp_256", rx_r[256], 8'h00);
    chk_eq("ramp_last", rx_r[SUM-1], 8'h2B);
    chk_eq("round_up", rx_g[0], 8'h13);
    chk_eq("round_down", rx_g[1], 8'h12);
`ifdef PIXEL_TX_SATURATE_EN
    chk_eq("sat_high", rx_g[2], 8'hFF);
    chk_eq("sat_low", rx_g[3], 8'h00);
`else
    chk_eq("wrap_high", rx_g[2], 8'h2C);
    chk_eq("wrap_low", rx_g[3], 8'hFB);
`endif

    // Frame 2: Ready toggling, write dropped mid-frame, rewrite in the DONE cycle.
    run_frame(1, -1, 1'b1, 1'b1, 1'b0, 1'b0);
    gap = done_cyc - first_vld_cyc;
    chk_eq("bp_done_gap_in_598_602", int'(gap >= 598 && gap <= 602), 1);
    chk_eq("mid_write_dropped", rx_r[SUM-1], 8'h2B);

    // Frame 3: random Ready, stray Start mid-stream, rewritten last pixel now visible.
    run_frame(2, -1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_eq("rewrite_visible", rx_r[SUM-1], 8'hAA);

    // Frame 4: reset after 100 pixels; Frame 5: fresh start with a write on the Start cycle.
    run_frame(0, 100, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(0, -1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
